// File: rtl/clk_gate_seq.sv
// clk_gate_seq: sequenced clock-gate controller.
// Applies requested per-channel clock enables one channel at a time, lowest
// index first. After each gate change the sequencer stays quiet for STAGGER
// cycles so that neighbouring gates never switch together.
// Optional feature macro: CLK_GATE_SEQ_IRQ_EN adds a one-cycle done_irq pulse
// when a pass ends with every gate matching its request.
module clk_gate_seq #(
    parameter int               N_CH     = 8,
    parameter int               STAGGER  = 16,
    parameter int               CNT_W    = 8,
    parameter logic [N_CH-1:0]  RST_MASK = '0
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          en_req,
    input  logic                     hold,
    output logic [N_CH-1:0]          gate_en,
    output logic                     busy,
    output logic [$clog2(N_CH)-1:0]  cur_ch,
    output logic                     settled
`ifdef CLK_GATE_SEQ_IRQ_EN
    ,output logic                    done_irq
`endif
);

    localparam int              CH_W     = $clog2(N_CH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STAGGER - 1);

    // A zero stagger or one that does not fit the counter would make the
    // counter wrap, so such configurations are rejected at elaboration.
    generate
        if (STAGGER < 1 || STAGGER > (2 ** CNT_W) - 1) begin : g_bad_stagger
            $error("clk_gate_seq: STAGGER must be in 1..2**CNT_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [N_CH-1:0]   gate_en_q, gate_en_d;
    logic              busy_q, busy_d;
    logic [N_CH-1:0]   diff;
    logic [N_CH-1:0]   apply_hit;
    logic [CH_W-1:0]   low_idx;

    assign diff = en_req ^ gate_en_q;

    // One-hot select of the channel being written during APPLY.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_hit
            assign apply_hit[gi] = (state_q == ST_APPLY) && (cur_ch_q == CH_W'(gi));
        end
    endgenerate

    // Lowest-index mismatching channel (scan from the top so index 0 wins).
    always_comb begin
        low_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (diff[i]) begin
                low_idx = CH_W'(i);
            end
        end
    end

    // Next-state, counter, channel latch and gate update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_ch_d  = cur_ch_q;
        gate_en_d = (gate_en_q & ~apply_hit) | (en_req & apply_hit);
        case (state_q)
            ST_IDLE: begin
                if ((diff != '0) && !hold) begin
                    cur_ch_d = low_idx;
                    state_d  = ST_APPLY;
                end
            end
            ST_APPLY: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!hold) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset restarts the sequence from scratch.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cur_ch_q  <= '0;
            gate_en_q <= RST_MASK;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_ch_q  <= cur_ch_d;
            gate_en_q <= gate_en_d;
            busy_q    <= busy_d;
        end
    end

    assign gate_en = gate_en_q;
    assign busy    = busy_q;
    assign cur_ch  = cur_ch_q;
    assign settled = (state_q == ST_IDLE) && (en_req == gate_en_q);

`ifdef CLK_GATE_SEQ_IRQ_EN
    logic done_irq_q, done_irq_d;

    // Pulse on the WAIT->IDLE edge only when nothing is left to correct.
    always_comb begin
        done_irq_d = (state_q == ST_WAIT) && !hold && (cnt_q == '0) &&
                     (en_req == gate_en_q);
    end

    // Completion pulse register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            done_irq_q <= 1'b0;
        end else begin
            done_irq_q <= done_irq_d;
        end
    end

    assign done_irq = done_irq_q;
`endif

endmodule

// File: tb/tb_clk_gate_seq.sv
// Testbench for clk_gate_seq: table-driven check of a STAGGER=1 instance,
// hand-written multi-cycle sequences and randomized stimulus against a
// behavioural model of the sequencing rules.
module tb_clk_gate_seq;

    localparam int STAG = 16;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] en_req = 8'h00;
    logic       hold   = 1'b0;
    logic [7:0] gate_en;
    logic       busy;
    logic [2:0] cur_ch;
    logic       settled;

    logic [3:0] en_s1   = 4'h0;
    logic [3:0] gate_s1;
    logic       busy_s1;
    logic [1:0] cur_s1;
    logic       settled_s1;

    logic [7:0] en_rm   = 8'hFF;
    logic [7:0] gate_rm;
    logic       busy_rm;
    logic [2:0] cur_rm;
    logic       settled_rm;

`ifdef CLK_GATE_SEQ_IRQ_EN
    logic done_irq, irq_s1, irq_rm;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model: gate vector, pending APPLY, remaining quiet cycles.
    logic [7:0] m_gate  = 8'h00;
    int         m_ch    = 0;
    bit         m_pend  = 0;
    int         m_quiet = 0;
    bit         m_irq   = 0;

    always #5 clk_in = ~clk_in;

    clk_gate_seq dut (
        .clk_in(clk_in), .rst_n(rst_n), .en_req(en_req), .hold(hold),
        .gate_en(gate_en), .busy(busy), .cur_ch(cur_ch), .settled(settled)
`ifdef CLK_GATE_SEQ_IRQ_EN
        , .done_irq(done_irq)
`endif
    );

    clk_gate_seq #(.N_CH(4), .STAGGER(1)) dut_s1 (
        .clk_in(clk_in), .rst_n(rst_n), .en_req(en_s1), .hold(1'b0),
        .gate_en(gate_s1), .busy(busy_s1), .cur_ch(cur_s1), .settled(settled_s1)
`ifdef CLK_GATE_SEQ_IRQ_EN
        , .done_irq(irq_s1)
`endif
    );

    clk_gate_seq #(.RST_MASK(8'hFF)) dut_rm (
        .clk_in(clk_in), .rst_n(rst_n), .en_req(en_rm), .hold(1'b0),
        .gate_en(gate_rm), .busy(busy_rm), .cur_ch(cur_rm), .settled(settled_rm)
`ifdef CLK_GATE_SEQ_IRQ_EN
        , .done_irq(irq_rm)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_gate = 8'h00; m_ch = 0; m_pend = 0; m_quiet = 0; m_irq = 0;
    endtask

    // One clock edge of the sequencing rules, using inputs seen before the edge.
    task automatic model_edge(input logic [7:0] en, input logic h);
        logic [7:0] d;
        int i;
        m_irq = 0;
        d = en ^ m_gate;
        if (m_pend) begin
            m_gate[m_ch] = en[m_ch];
            m_pend  = 0;
            m_quiet = STAG;
        end else if (m_quiet > 0) begin
            if (!h) begin
                m_quiet--;
                if (m_quiet == 0 && en == m_gate) m_irq = 1;
            end
        end else if (d != 8'h00 && !h) begin
            i = 0;
            while (!d[i]) i++;
            m_ch   = i;
            m_pend = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        bit m_busy;
        m_busy = m_pend || (m_quiet > 0);
        chk({tag, "_gate"}, 32'(gate_en), 32'(m_gate));
        chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
        chk({tag, "_cur"}, 32'(cur_ch), 32'(m_ch));
        chk({tag, "_settled"}, 32'(settled), 32'(!m_busy && en_req == m_gate));
`ifdef CLK_GATE_SEQ_IRQ_EN
        chk({tag, "_irq"}, 32'(done_irq), 32'(m_irq));
`endif
        chk({tag, "_rm_gate"}, 32'(gate_rm), 32'hFF);
        chk({tag, "_rm_busy"}, 32'(busy_rm), 32'h0);
        chk({tag, "_rm_settled"}, 32'(settled_rm), 32'h1);
    endtask

    // Drive inputs, advance one edge, update model, compare #1 after the edge.
    task automatic step(input string tag, input logic [7:0] en, input logic h);
        en_req = en;
        hold   = h;
        @(posedge clk_in);
        model_edge(en, h);
        #1;
        compare_all(tag);
    endtask

    typedef struct {
        logic [3:0] gate;
        logic       busy;
        logic [1:0] cur;
        logic       settled;
    } s1_vec_t;

    s1_vec_t s1_tab [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // STAGGER=1, N_CH=4, request 0->F: one update every 3 edges.
        s1_tab[0]  = '{4'h0, 1'b1, 2'd0, 1'b0};
        s1_tab[1]  = '{4'h1, 1'b1, 2'd0, 1'b0};
        s1_tab[2]  = '{4'h1, 1'b0, 2'd0, 1'b0};
        s1_tab[3]  = '{4'h1, 1'b1, 2'd1, 1'b0};
        s1_tab[4]  = '{4'h3, 1'b1, 2'd1, 1'b0};
        s1_tab[5]  = '{4'h3, 1'b0, 2'd1, 1'b0};
        s1_tab[6]  = '{4'h3, 1'b1, 2'd2, 1'b0};
        s1_tab[7]  = '{4'h7, 1'b1, 2'd2, 1'b0};
        s1_tab[8]  = '{4'h7, 1'b0, 2'd2, 1'b0};
        s1_tab[9]  = '{4'h7, 1'b1, 2'd3, 1'b0};
        s1_tab[10] = '{4'hF, 1'b1, 2'd3, 1'b0};
        s1_tab[11] = '{4'hF, 1'b0, 2'd3, 1'b1};

        // Reset state.
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_gate", 32'(gate_en), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rm_gate", 32'(gate_rm), 32'hFF);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) step("idle", 8'h00, 1'b0);

        // Table-driven STAGGER=1 instance.
        en_s1 = 4'hF;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk_in);
            #1;
            $display("s1 edge k+%0d gate=%h busy=%0d cur=%0d", j, gate_s1, busy_s1, cur_s1);
            chk("s1_gate", 32'(gate_s1), 32'(s1_tab[j].gate));
            chk("s1_busy", 32'(busy_s1), 32'(s1_tab[j].busy));
            chk("s1_cur", 32'(cur_s1), 32'(s1_tab[j].cur));
            chk("s1_settled", 32'(settled_s1), 32'(s1_tab[j].settled));
        end

        // 0x00 -> 0x81: bit0 at k+1, bit7 at k+19, busy falls at k+35.
        for (int j = 0; j < 40; j++) begin
            step("seq81", 8'h81, 1'b0);
            if (j == 1)  chk("seq81_bit0", 32'(gate_en), 32'h01);
            if (j == 18) chk("seq81_pre7", 32'(gate_en), 32'h01);
            if (j == 19) chk("seq81_bit7", 32'(gate_en), 32'h81);
            if (j == 34) chk("seq81_busy_hi", 32'(busy), 32'h1);
            if (j == 35) chk("seq81_busy_lo", 32'(busy), 32'h0);
            if (j == 35) chk("seq81_settled", 32'(settled), 32'h1);
        end
        for (int j = 0; j < 40; j++) step("clr", 8'h00, 1'b0);

        // Hold 5 edges during WAIT delays the second channel from k+19 to k+24.
        for (int j = 0; j < 45; j++) begin
            step("hold", 8'h03, (j >= 5 && j <= 9));
            if (j == 1)  chk("hold_bit0", 32'(gate_en), 32'h01);
            if (j == 19) chk("hold_delayed", 32'(gate_en), 32'h01);
            if (j == 23) chk("hold_pre1", 32'(gate_en), 32'h01);
            if (j == 24) chk("hold_bit1", 32'(gate_en), 32'h03);
        end
        for (int j = 0; j < 45; j++) step("clr", 8'h00, 1'b0);

        // Request bit0 for two edges only: set at k+1, cleared at k+19.
        for (int j = 0; j < 40; j++) begin
            step("revert", (j < 2) ? 8'h01 : 8'h00, 1'b0);
            if (j == 1)  chk("revert_set", 32'(gate_en), 32'h01);
            if (j == 18) chk("revert_still", 32'(gate_en), 32'h01);
            if (j == 19) chk("revert_clr", 32'(gate_en), 32'h00);
        end

        // Asynchronous reset mid-WAIT with cur_ch non-zero.
        for (int j = 0; j < 6; j++) step("prerst", 8'h10, 1'b0);
        chk("prerst_cur", 32'(cur_ch), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gate", 32'(gate_en), 32'h00);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_cur", 32'(cur_ch), 32'h0);
        model_reset();
        @(posedge clk_in);
        #1;
        compare_all("inrst");
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) step("postrst", 8'h00, 1'b0);

        // Randomized traffic against the model.
        begin
            logic [7:0] en;
            logic       h;
            en = 8'h00;
            for (int j = 0; j < 1500; j++) begin
                if ($urandom_range(0, 19) == 0) en = 8'($urandom);
                else if ($urandom_range(0, 29) == 0) en[$urandom_range(0, 7)] ^= 1'b1;
                h = ($urandom_range(0, 7) == 0);
                step("rand", en, h);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
